// File: rtl/sha256_msg_schedule_if.sv
// SHA-256 message-schedule stream interface.
//   in_valid/in_ready/in_data        : 32-bit message words M[0..15], big-endian word order
//   out_valid/out_ready/out_data     : schedule words W[0..63]
//   out_idx                          : t of the word on out_data
//   out_last                         : high with W[63]
// slave  : the schedule block (consumes M, produces W)
// master : the surrounding logic (produces M, consumes W)
interface sha256_msg_schedule_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule.
// Loads one 512-bit block as 16 words into a 16-entry sliding window, then
// emits W[0..63] one per accepted output transfer. Every accepted word shifts
// the window down and appends W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any block in progress
//   bus  : stream interface (slave side), see sha256_msg_schedule_if
module sha256_msg_schedule #(
    parameter int WORDS_IN = 16,
    parameter int ROUNDS   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_msg_schedule_if.slave   bus
);
    localparam int CW = $clog2(WORDS_IN);
    localparam int TW = $clog2(ROUNDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_IN - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(ROUNDS - 1);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t                       state;
    logic [WORDS_IN-1:0][31:0]    win;
    logic [CW-1:0]                cnt;
    logic [TW-1:0]                t;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         out_last_q;
    logic [31:0]                  wnext;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win[0] is always W[t]; the taps below are W[t+14], W[t+9], W[t+1], W[t].
    assign wnext = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

    // Outputs come straight from state registers: the head of the window is
    // the presented word and t is its index.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = win[0];
    assign bus.out_idx   = t;
    assign bus.out_last  = out_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            win         <= '0;
            cnt         <= '0;
            t           <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone marks a transfer.
                    if (bus.in_valid) begin
                        win[cnt] <= bus.in_data;
                        if (cnt == CNT_LAST) begin
                            cnt         <= '0;
                            t           <= '0;
                            state       <= EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        for (int i = 0; i < WORDS_IN - 1; i++)
                            win[i] <= win[i+1];
                        // Words produced for t >= 48 are never emitted; computing
                        // them anyway keeps the datapath free of special cases.
                        win[WORDS_IN-1] <= wnext;
                        if (t == T_LAST) begin
                            t           <= '0;
                            state       <= LOAD;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            t          <= t + 1'b1;
                            out_last_q <= (t == T_LAST - 1'b1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_schedule_if bus();

    sha256_msg_schedule #(.WORDS_IN(16), .ROUNDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       nm;
        int          blk;   // 0: "abc" block, 1: all-ones block
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];
    int nvec = 0;
    int nerr = 0;

    logic [15:0][31:0] m_abc, m_ones, m_b3;
    logic [63:0][31:0] w_abc, w_ones, w_b3;
    logic [63:0][31:0] got;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0][31:0] model(input logic [15:0][31:0] m);
        logic [63:0][31:0] w;
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %08h expected %08h", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s @%0t: timed out", nm, $time);
    endtask

    // Feeds msg[start..nwords-1]; gapmax > 0 inserts 1..gapmax idle cycles between words.
    task automatic load_block(input logic [15:0][31:0] msg, input int gapmax, input int nwords, input int start);
        int i = start, gap = 0, cyc = 0;
        while (i < nwords && cyc < 500) begin
            @(negedge clk); cyc++;
            if (gap > 0) begin
                bus.in_valid = 1'b0; gap--;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = msg[i];
                if (bus.in_ready) begin
                    i++;
                    gap = (gapmax > 0) ? int'($urandom_range(1, gapmax)) : 0;
                end
            end
        end
        if (i < nwords) timeout("load");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Drains W words, checking each against exp. Stops once t == stop_at is
    // presented (stop_at < 0 drains all 64).
    task automatic collect(input logic [63:0][31:0] exp, input bit bp, input bit hold_in,
                           input bit offer, input logic [31:0] offer_word, input int stop_at);
        int t = 0, cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] ld = '0;
        logic [5:0]  li = '0;
        while (t < 64 && t != stop_at && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (hold_in) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 32'hDEAD0000 | 32'(t);
                chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
            end
            if (offer && t == 63) begin
                bus.in_valid = 1'b1;
                bus.in_data  = offer_word;
                chk("in_ready_t63", 32'(bus.in_ready), 32'd0);
            end
            if (!bus.out_valid) begin
                chk("out_valid", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_data", bus.out_data, ld);
                    chk("stall_idx", 32'(bus.out_idx), 32'(li));
                end
                chk("idx", 32'(bus.out_idx), 32'(t));
                chk("data", bus.out_data, exp[t]);
                chk("last", 32'(bus.out_last), (t == 63) ? 32'd1 : 32'd0);
                got[t] = bus.out_data;
                ld = bus.out_data;
                li = bus.out_idx;
                bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                stalled = !bus.out_ready;
                if (bus.out_ready) t++;
            end
        end
        if (t < 64 && t != stop_at) timeout("collect");
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (hold_in) bus.in_valid = 1'b0;
    endtask

    task automatic end_chk(input string nm);
        @(negedge clk);
        chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic reset_pulse;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_out_data"}, bus.out_data, 32'd0);
        chk({nm, "_out_idx"}, 32'(bus.out_idx), 32'd0);
        chk({nm, "_out_last"}, 32'(bus.out_last), 32'd0);
    endtask

    task automatic tbl_chk(input int blk);
        for (int k = 0; k < 7; k++)
            if (tbl[k].blk == blk) chk(tbl[k].nm, got[tbl[k].idx], tbl[k].exp);
    endtask

    initial begin
        tbl[0] = '{"abc_w0",   0, 0,  32'h61626380};
        tbl[1] = '{"abc_w15",  0, 15, 32'h00000018};
        tbl[2] = '{"abc_w16",  0, 16, 32'h61626380};
        tbl[3] = '{"abc_w17",  0, 17, 32'h000F0000};
        tbl[4] = '{"abc_w63",  0, 63, 32'h12B1EDEB};
        tbl[5] = '{"ones_w0",  1, 0,  32'hFFFFFFFF};
        // s1 = 003FFFFF, s0 = 1FFFFFFF, plus two 0xFFFFFFFF terms, wrapped mod 2^32.
        tbl[6] = '{"ones_w16", 1, 16, 32'h203FFFFC};

        m_abc = '0;
        m_abc[0]  = 32'h61626380;
        m_abc[15] = 32'h00000018;
        m_ones = '1;
        for (int i = 0; i < 16; i++) m_b3[i] = 32'h01234567 ^ (32'(i) * 32'h11111111);
        w_abc  = model(m_abc);
        w_ones = model(m_ones);
        w_b3   = model(m_b3);

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        got = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rst_chk("reset");

        // "abc" block, no stalls
        load_block(m_abc, 0, 16, 0);
        collect(w_abc, 1'b0, 1'b0, 1'b0, 32'h0, -1);
        tbl_chk(0);
        end_chk("abc_end");

        // Backpressure
        load_block(m_abc, 0, 16, 0);
        collect(w_abc, 1'b1, 1'b0, 1'b0, 32'h0, -1);
        tbl_chk(0);

        // Gapped input; in_valid held high while emitting
        load_block(m_abc, 3, 16, 0);
        collect(w_abc, 1'b0, 1'b1, 1'b0, 32'h0, -1);
        tbl_chk(0);

        // Reset after 9 words, then the all-ones block
        load_block(m_abc, 0, 9, 0);
        reset_pulse();
        rst_chk("rst_load");
        load_block(m_ones, 0, 16, 0);
        collect(w_ones, 1'b1, 1'b0, 1'b0, 32'h0, -1);
        tbl_chk(1);

        // Reset at t = 30, then a clean reload
        load_block(m_abc, 0, 16, 0);
        collect(w_abc, 1'b0, 1'b0, 1'b0, 32'h0, 30);
        @(negedge clk);
        chk("t30_idx", 32'(bus.out_idx), 32'd30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rst_chk("rst_emit");
        load_block(m_b3, 0, 16, 0);
        collect(w_b3, 1'b0, 1'b0, 1'b0, 32'h0, -1);

        // Back-to-back: block 2 word 0 offered while t = 63 is presented
        load_block(m_abc, 0, 16, 0);
        collect(w_abc, 1'b0, 1'b0, 1'b1, m_b3[0], -1);
        @(negedge clk);
        chk("b2b_out_valid", 32'(bus.out_valid), 32'd0);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        load_block(m_b3, 0, 16, 1);
        collect(w_b3, 1'b1, 1'b0, 1'b0, 32'h0, -1);
        end_chk("b2b_end");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
